multi_chan_start_counter: RTL and testbench
===========================================

Name: multi_chan_start_counter

Overview:
Parametrised successor of the single 8-bit start/count block. It provides NCHAN independent counters of WIDTH bits. Each channel is launched by its own start pulse and runs in a mode latched at start: one-shot, wrap or saturate. Done and wrap events are reported as single-cycle pulses. It sits beside the sequencing logic as the shared timing and event-count resource.

Parameters:
WIDTH, 8, counter width per channel in bits (>=2)
NCHAN, 4, number of independent channels (>=1)

Ports:
clk  input  1  system clock; all logic is rising-edge
reset  input  1  synchronous, active-high reset
start  input  NCHAN  per-channel start/restart request, sampled each cycle
stop  input  NCHAN  per-channel abort request
mode  input  2*NCHAN  per-channel mode, bits [2i+1:2i]; latched on start
limit  input  WIDTH*NCHAN  per-channel terminal value; latched on start
count  output  WIDTH*NCHAN  per-channel current count, registered
busy  output  NCHAN  channel is in RUN or HOLD
done  output  NCHAN  1-cycle pulse: one-shot reached limit
wrap  output  NCHAN  1-cycle pulse: wrap-mode rollover, or saturate-mode arrival at limit

Behaviour:
- Reset (sync, active-high):
  - every channel goes to IDLE.
  - count=0, busy=0, done=0, wrap=0; latched mode and limit are cleared to 0.
  - reset overrides start/stop in the same cycle.
- Modes:
  - 0 ONESHOT.
  - 1 WRAP.
  - 2 SATURATE.
  - 3 is reserved and behaves exactly as ONESHOT.
- Per-channel FSM has states IDLE, RUN, HOLD.
  - IDLE: on start -> RUN. Next cycle count=0, busy=1, mode and limit latched.
  - RUN, count<limit: count increments by 1 each cycle.
  - RUN, count==limit, ONESHOT: next cycle -> IDLE, done=1 for one cycle, busy=0, count holds limit.
  - RUN, count==limit, WRAP: next cycle count=0, wrap=1 for one cycle, stays RUN.
  - RUN, count==limit, SATURATE: -> HOLD, wrap=1 for one cycle on entry, count holds limit, busy stays 1.
  - HOLD: stays until stop or start.
  - stop in RUN or HOLD -> IDLE next cycle. count is frozen at its current value; no done or wrap pulse.
- Latency: start in cycle N gives count=0 in N+1 and count=1 in N+2. Time to done = limit+1 cycles after the start edge.
- Start in RUN or HOLD: restart. count=0 next cycle, new mode and limit latched, any pending done/wrap suppressed.
- start and stop in the same cycle: start wins (restart).
- limit=0:
  - ONESHOT: done in the cycle after count=0 is shown.
  - WRAP: wrap pulses every cycle, count stays 0.
  - SATURATE: HOLD immediately after the first count=0 cycle.
- Arithmetic: count never exceeds limit, and no modular overflow past limit is possible.
- Channels are fully independent, with no cross-channel priority.

Optional Feature:
MULTI_CHAN_START_COUNTER_PRESCALE_EN
- Defined: adds input tick (NCHAN bits).
  - In RUN, count advances, and limit comparison/transitions occur, only in cycles where tick[i]=1.
  - start, stop and reset act regardless of tick.
  - The count=0 load on start does not need tick.
- Undefined: no tick port; behaves as if tick is constantly all-ones.

Decomposition:
- Package multi_chan_start_counter_pkg holds:
  - typedef enum logic [1:0] cnt_mode_e {CNT_ONESHOT, CNT_WRAP, CNT_SAT, CNT_RSVD}
  - typedef enum logic [1:0] cnt_state_e {ST_IDLE, ST_RUN, ST_HOLD}
- Sub-module start_counter_chan holds one channel's FSM, counter and limit/mode registers, parameterised by WIDTH.
- The top level is a generate loop over NCHAN plus port slicing only.

Test Plan:
- Reset then idle: hold reset 3 cycles -> count=0, busy=0, done=0, wrap=0 on all channels; start asserted during reset is ignored.
- ONESHOT ch0, limit=5: start pulse at cycle 10 -> count 0..5 in cycles 11..16, done=1 in cycle 17 only, busy falls in cycle 17, count holds 5.
- WRAP ch1, limit=3 for 12 cycles -> count sequence 0,1,2,3,0,..., wrap pulses each time count returns to 0; stop -> busy=0, count frozen, no pulse.
- SATURATE ch2, limit=255 (WIDTH=8) -> HOLD at 255, wrap pulses once, busy stays 1; then start and stop in the same cycle -> restart, count=0 next cycle.
- Restart mid-run ch3, ONESHOT limit=10: restart at count=4 with limit=2 -> count 0,1,2 then done; no done from the original run; other channels unaffected.
- With MULTI_CHAN_START_COUNTER_PRESCALE_EN, tick every 3rd cycle, limit=2 -> done arrives roughly 3x later than without the macro; count changes only on tick cycles.

Source files
------------

// File: rtl/multi_chan_start_counter_pkg.sv
// rtl/multi_chan_start_counter_pkg.sv - shared types for the multi-channel start counter
//
// Purpose: mode and per-channel FSM state encodings used by the counter
//          channel and the top level.
// Contents:
//   cnt_mode_e  - count mode latched at start (reserved code acts as one-shot)
//   cnt_state_e - per-channel FSM state

package multi_chan_start_counter_pkg;

    typedef enum logic [1:0] {
        CNT_ONESHOT = 2'd0,
        CNT_WRAP    = 2'd1,
        CNT_SAT     = 2'd2,
        CNT_RSVD    = 2'd3
    } cnt_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/start_counter_chan.sv
// rtl/start_counter_chan.sv - one channel of the start/count timer
//
// Purpose: FSM, counter and latched mode/limit for a single channel.
// Ports:
//   i_clk, i_reset      - clock and synchronous active-high reset
//   i_start, i_stop     - start/restart and abort requests (start wins)
//   i_tick              - count enable while running
//   i_mode, i_limit     - mode and terminal value, latched on start
//   o_count             - registered current count
//   o_busy              - channel in RUN or HOLD
//   o_done, o_wrap      - single-cycle event pulses

module start_counter_chan
    import multi_chan_start_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_tick,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_wrap
);

    cnt_state_e       r_state;
    cnt_mode_e        r_mode;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] r_count;
    logic             r_done;
    logic             r_wrap;

    cnt_state_e       w_next_state;
    logic [WIDTH-1:0] w_count_next;
    logic             w_done_next;
    logic             w_wrap_next;
    logic             w_at_limit;
    logic             w_advance;

    assign w_at_limit = (r_count == r_limit);
    // Counting and limit handling only happen on enabled cycles in RUN.
    assign w_advance  = (r_state == ST_RUN) && i_tick;

    // State, counter and latched configuration registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_mode  <= CNT_ONESHOT;
            r_limit <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_count_next;
            r_done  <= w_done_next;
            r_wrap  <= w_wrap_next;
            if (i_start) begin
                r_mode  <= cnt_mode_e'(i_mode);
                r_limit <= i_limit;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (i_start) begin
            w_next_state = ST_RUN;
        end else if (i_stop && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
        end else if (w_advance && w_at_limit) begin
            case (r_mode)
                CNT_WRAP: w_next_state = ST_RUN;
                CNT_SAT:  w_next_state = ST_HOLD;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // Counter and event pulse next values; a restart or stop suppresses
    // any event that the current cycle would otherwise have produced.
    always_comb begin
        w_count_next = r_count;
        w_done_next  = 1'b0;
        w_wrap_next  = 1'b0;
        if (i_start) begin
            w_count_next = '0;
        end else if (i_stop && (r_state != ST_IDLE)) begin
            w_count_next = r_count;
        end else if (w_advance) begin
            if (w_at_limit) begin
                case (r_mode)
                    CNT_WRAP: begin
                        w_count_next = '0;
                        w_wrap_next  = 1'b1;
                    end
                    CNT_SAT:  w_wrap_next = 1'b1;
                    default:  w_done_next = 1'b1;
                endcase
            end else begin
                // count < limit here, so the increment cannot overflow
                w_count_next = r_count + WIDTH'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        o_busy  = (r_state != ST_IDLE);
        o_count = r_count;
        o_done  = r_done;
        o_wrap  = r_wrap;
    end

endmodule

// File: rtl/multi_chan_start_counter.sv
// rtl/multi_chan_start_counter.sv - NCHAN independent start/count timers
//
// Purpose: replicates start_counter_chan NCHAN times and slices the packed
//          per-channel buses.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   start, stop         - per-channel start/restart and abort requests
//   mode [2*NCHAN]      - per-channel mode, bits [2i+1:2i]
//   limit [WIDTH*NCHAN] - per-channel terminal value
//   tick [NCHAN]        - per-channel count enable (MULTI_CHAN_START_COUNTER_PRESCALE_EN only)
//   count [WIDTH*NCHAN] - per-channel registered count
//   busy, done, wrap    - per-channel status and event pulses
// Build option: MULTI_CHAN_START_COUNTER_PRESCALE_EN adds the tick input;
//               without it every channel counts every cycle.

module multi_chan_start_counter #(
    parameter int WIDTH = 8,
    parameter int NCHAN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCHAN-1:0]       start,
    input  logic [NCHAN-1:0]       stop,
    input  logic [2*NCHAN-1:0]     mode,
    input  logic [WIDTH*NCHAN-1:0] limit,
`ifdef MULTI_CHAN_START_COUNTER_PRESCALE_EN
    input  logic [NCHAN-1:0]       tick,
`endif
    output logic [WIDTH*NCHAN-1:0] count,
    output logic [NCHAN-1:0]       busy,
    output logic [NCHAN-1:0]       done,
    output logic [NCHAN-1:0]       wrap
);

    logic [NCHAN-1:0] w_tick;

`ifdef MULTI_CHAN_START_COUNTER_PRESCALE_EN
    assign w_tick = tick;
`else
    assign w_tick = '1;
`endif

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
        start_counter_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .i_clk   (clk),
            .i_reset (reset),
            .i_start (start[gi]),
            .i_stop  (stop[gi]),
            .i_tick  (w_tick[gi]),
            .i_mode  (mode[2*gi +: 2]),
            .i_limit (limit[WIDTH*gi +: WIDTH]),
            .o_count (count[WIDTH*gi +: WIDTH]),
            .o_busy  (busy[gi]),
            .o_done  (done[gi]),
            .o_wrap  (wrap[gi])
        );
    end

endmodule

// File: tb/tb_multi_chan_start_counter.sv
// tb/tb_multi_chan_start_counter.sv - directed self-checking bench for multi_chan_start_counter

module tb_multi_chan_start_counter;

    localparam int WIDTH = 8;
    localparam int NCHAN = 4;

    logic                   clk;
    logic                   reset;
    logic [NCHAN-1:0]       start;
    logic [NCHAN-1:0]       stop;
    logic [2*NCHAN-1:0]     mode;
    logic [WIDTH*NCHAN-1:0] limit;
    logic [NCHAN-1:0]       tick;
    logic [WIDTH*NCHAN-1:0] count;
    logic [NCHAN-1:0]       busy;
    logic [NCHAN-1:0]       done;
    logic [NCHAN-1:0]       wrap;

    int n_checks;
    int n_fail;

    multi_chan_start_counter #(
        .WIDTH (WIDTH),
        .NCHAN (NCHAN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .limit (limit),
`ifdef MULTI_CHAN_START_COUNTER_PRESCALE_EN
        .tick  (tick),
`endif
        .count (count),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] cnt(input int c);
        return count[c*WIDTH +: WIDTH];
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with start asserted on every channel: start must be ignored
        reset = 1'b1;
        start = '1;
        stop  = '0;
        mode  = '0;
        limit = {NCHAN{8'd5}};
        tick  = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_count", count, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_wrap", wrap, 0);
        end
        reset = 1'b0;
        start = '0;
        @(negedge clk);
        chk("idle_count", count, 0);
        chk("idle_busy", busy, 0);

        // ONESHOT ch0, limit 5
        mode[1:0]  = 2'd0;
        limit[7:0] = 8'd5;
        start[0]   = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("os_count0", cnt(0), 0);
        chk("os_busy0", busy[0], 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("os_count", cnt(0), k);
            chk("os_nodone", done[0], 0);
            chk("os_busy", busy[0], 1);
        end
        @(negedge clk);
        chk("os_done", done[0], 1);
        chk("os_busy_fall", busy[0], 0);
        chk("os_count_hold", cnt(0), 5);
        @(negedge clk);
        chk("os_done_pulse", done[0], 0);
        chk("os_count_hold2", cnt(0), 5);

        // WRAP ch1, limit 3, then stop
        mode[3:2]   = 2'd1;
        limit[15:8] = 8'd3;
        start[1]    = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        chk("wr_count", cnt(1), 0);
        chk("wr_wrap", wrap[1], 0);
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            chk("wr_count", cnt(1), i % 4);
            chk("wr_wrap", wrap[1], (i % 4) == 0);
            chk("wr_busy", busy[1], 1);
        end
        stop[1] = 1'b1;
        @(negedge clk);
        stop[1] = 1'b0;
        chk("wr_stop_busy", busy[1], 0);
        chk("wr_stop_count", cnt(1), 3);
        chk("wr_stop_wrap", wrap[1], 0);
        @(negedge clk);
        chk("wr_frozen", cnt(1), 3);
        chk("wr_nopulse", wrap[1], 0);

        // SATURATE ch2, limit 255
        mode[5:4]    = 2'd2;
        limit[23:16] = 8'd255;
        start[2]     = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            chk("sat_count", cnt(2), i);
            chk("sat_wrap", wrap[2], 0);
        end
        @(negedge clk);
        chk("sat_hold_count", cnt(2), 255);
        chk("sat_wrap_pulse", wrap[2], 1);
        chk("sat_busy", busy[2], 1);
        @(negedge clk);
        chk("sat_hold_count2", cnt(2), 255);
        chk("sat_wrap_once", wrap[2], 0);
        chk("sat_busy2", busy[2], 1);
        start[2] = 1'b1;
        stop[2]  = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        chk("sat_restart_count", cnt(2), 0);
        chk("sat_restart_busy", busy[2], 1);
        @(negedge clk);
        stop[2] = 1'b0;
        chk("sat_stop_busy", busy[2], 0);

        // ONESHOT ch3, limit 10, restarted at count 4 with limit 2
        mode[7:6]    = 2'd0;
        limit[31:24] = 8'd10;
        start[3]     = 1'b1;
        @(negedge clk);
        start[3] = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("rs_count", cnt(3), i);
        end
        limit[31:24] = 8'd2;
        start[3]     = 1'b1;
        @(negedge clk);
        start[3] = 1'b0;
        chk("rs_count0", cnt(3), 0);
        @(negedge clk);
        chk("rs_count1", cnt(3), 1);
        @(negedge clk);
        chk("rs_count2", cnt(3), 2);
        chk("rs_nodone", done[3], 0);
        @(negedge clk);
        chk("rs_done", done[3], 1);
        chk("rs_busy_fall", busy[3], 0);
        chk("rs_count_hold", cnt(3), 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rs_no_old_done", done[3], 0);
        end
        chk("other_ch0", cnt(0), 5);
        chk("other_ch1", cnt(1), 3);
        chk("other_busy", busy, 0);

        // limit 0: ONESHOT on ch0, WRAP on ch1
        limit[7:0]  = 8'd0;
        limit[15:8] = 8'd0;
        start[1:0]  = 2'b11;
        @(negedge clk);
        start[1:0] = 2'b00;
        chk("l0_os_count", cnt(0), 0);
        chk("l0_os_nodone", done[0], 0);
        chk("l0_wr_nowrap", wrap[1], 0);
        @(negedge clk);
        chk("l0_os_done", done[0], 1);
        chk("l0_os_busy", busy[0], 0);
        for (int i = 0; i < 3; i++) begin
            chk("l0_wr_wrap", wrap[1], 1);
            chk("l0_wr_count", cnt(1), 0);
            @(negedge clk);
        end
        stop[1] = 1'b1;
        @(negedge clk);
        stop[1] = 1'b0;
        chk("l0_wr_stop", busy[1], 0);

`ifdef MULTI_CHAN_START_COUNTER_PRESCALE_EN
        // Prescaled ONESHOT ch0, limit 2, tick every third cycle
        begin
            int  exp_c;
            bit  exp_run;
            bit  exp_done;
            bit  t;
            limit[7:0] = 8'd2;
            tick[0]    = 1'b0;
            start[0]   = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
            chk("ps_count0", cnt(0), 0);
            exp_c   = 0;
            exp_run = 1'b1;
            for (int i = 0; i < 12; i++) begin
                t       = ((i % 3) == 2);
                tick[0] = t;
                @(negedge clk);
                exp_done = 1'b0;
                if (exp_run && t) begin
                    if (exp_c < 2) exp_c++;
                    else begin
                        exp_run  = 1'b0;
                        exp_done = 1'b1;
                    end
                end
                chk("ps_count", cnt(0), exp_c);
                chk("ps_done", done[0], exp_done);
                chk("ps_busy", busy[0], exp_run);
            end
            tick = '1;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
